// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
//   Single-clock FIFO with storage, pointers and status in one block.
//   Read data is registered and qualified by a one-cycle rd_valid strobe.
//   Status (count, full, empty, almost flags) comes from the registered
//   pointers only, so it changes in the cycle after an accepting edge.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   w_en/data_in  write request and data
//   r_en          read request
//   flush         synchronous clear of pointers (contents discarded)
//   clr_err       synchronous clear of sticky overflow/underflow
//   data_out      registered read data, holds between reads
//   rd_valid      data_out was updated on the last edge
//   full/empty    DEPTH / zero entries stored
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty

module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AFULL_TH   = 6,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] AFULL_C  = (PTR_WIDTH+1)'(AFULL_TH);
  localparam logic [PTR_WIDTH:0] AEMPTY_C = (PTR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH:0]    wptr;
  logic [PTR_WIDTH:0]    rptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Accepts use the flags held at the start of the cycle; flush drops both.
  assign wr_acc = w_en & ~full  & ~flush;
  assign rd_acc = r_en & ~empty & ~flush;

  // Extra MSB on each pointer tells full (MSBs differ) from empty (equal).
  assign count        = wptr - rptr;
  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_WIDTH] != rptr[PTR_WIDTH]) &&
                        (wptr[PTR_WIDTH-1:0] == rptr[PTR_WIDTH-1:0]);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[PTR_WIDTH-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_acc) begin
        data_out <= mem[rptr[PTR_WIDTH-1:0]];
        rptr     <= rptr + PTR_ONE;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Error flags: a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl
//   Directed bench for sync_fifo_ctrl (DATA_WIDTH=8, DEPTH=8, AFULL_TH=6,
//   AEMPTY_TH=2). Inputs change 1 ns after a rising edge; outputs are
//   checked at that same point, i.e. they reflect the preceding edge.

module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic       flush;
  logic       clr_err;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .PTR_WIDTH (3),
    .AFULL_TH  (6),
    .AEMPTY_TH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .w_en        (w_en),
    .data_in     (data_in),
    .r_en        (r_en),
    .flush       (flush),
    .clr_err     (clr_err),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Snapshot of every status output against hand-computed values.
  task automatic check_status(input string tag, input logic [3:0] e_count,
                              input logic e_full, input logic e_empty,
                              input logic e_af, input logic e_ae);
    check({tag, ".count"},        count,        e_count);
    check({tag, ".full"},         full,         e_full);
    check({tag, ".empty"},        empty,        e_empty);
    check({tag, ".almost_full"},  almost_full,  e_af);
    check({tag, ".almost_empty"}, almost_empty, e_ae);
  endtask

  initial begin
    rst_n   = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    data_in = 8'h00;
    tick();
    tick();

    // Reset values
    check_status("rst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst.data_out",  data_out,  8'h00);
    check("rst.rd_valid",  rd_valid,  1'b0);
    check("rst.overflow",  overflow,  1'b0);
    check("rst.underflow", underflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: fill with 0x11..0x18, then overflow
    w_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h11 + 8'(i);
      tick();
      check_status("fill", 4'(i + 1), (i == 7), 1'b0, (i >= 5), (i <= 1));
    end
    data_in = 8'h99;
    tick();
    check_status("ovf", 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ovf.overflow",  overflow,  1'b1);
    check("ovf.underflow", underflow, 1'b0);

    // 2: drain in order, then underflow
    w_en = 1'b0;
    r_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("drain.data_out", data_out, 8'h11 + 8'(i));
      check("drain.rd_valid", rd_valid, 1'b1);
      check_status("drain", 4'(7 - i), 1'b0, (i == 7), (i <= 1), (i >= 5));
    end
    tick();
    check("udf.underflow", underflow, 1'b1);
    check("udf.rd_valid",  rd_valid,  1'b0);
    check("udf.data_out",  data_out,  8'h18);
    check("udf.overflow_sticky", overflow, 1'b1);
    r_en    = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr1.overflow",  overflow,  1'b0);
    check("clr1.underflow", underflow, 1'b0);

    // 3: fill 4, then 20 cycles of simultaneous read/write across wraps
    w_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h20 + 8'(i);
      tick();
    end
    check("pre_stream.count", count, 4'd4);
    r_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'h24 + 8'(i);
      tick();
      check("stream.data_out", data_out, 8'h20 + 8'(i));
      check("stream.count",    count,    4'd4);
    end
    check("stream.overflow",  overflow,  1'b0);
    check("stream.underflow", underflow, 1'b0);
    w_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tail.data_out", data_out, 8'h34 + 8'(i));
    end
    r_en = 1'b0;
    tick();
    check_status("tail", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // 4a: empty with w_en & r_en -> write only, underflow
    w_en    = 1'b1;
    r_en    = 1'b1;
    data_in = 8'h55;
    tick();
    check("e_rw.count",     count,     4'd1);
    check("e_rw.rd_valid",  rd_valid,  1'b0);
    check("e_rw.data_out",  data_out,  8'h37);
    check("e_rw.underflow", underflow, 1'b1);
    r_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      data_in = 8'h56 + 8'(i);
      tick();
    end
    check("f_pre.full", full, 1'b1);

    // 4b: full with w_en & r_en -> read only, overflow
    r_en    = 1'b1;
    data_in = 8'hEE;
    tick();
    check("f_rw.data_out", data_out, 8'h55);
    check("f_rw.rd_valid", rd_valid, 1'b1);
    check("f_rw.count",    count,    4'd7);
    check("f_rw.overflow", overflow, 1'b1);

    // 5: bring count to 5, flush with a write pending
    w_en = 1'b0;
    tick();
    check("pre_fl.data_out", data_out, 8'h56);
    tick();
    check("pre_fl.data_out2", data_out, 8'h57);
    check("pre_fl.count",     count,    4'd5);
    r_en    = 1'b0;
    w_en    = 1'b1;
    flush   = 1'b1;
    data_in = 8'hAA;
    tick();
    flush = 1'b0;
    w_en  = 1'b0;
    check_status("flush", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush.rd_valid",  rd_valid,  1'b0);
    check("flush.data_out",  data_out,  8'h57);
    check("flush.overflow",  overflow,  1'b1);
    check("flush.underflow", underflow, 1'b1);
    tick();
    check("flush.no_write.count", count, 4'd0);

    // Set beats clear: read-while-empty in the clr_err cycle keeps underflow
    r_en    = 1'b1;
    clr_err = 1'b1;
    tick();
    check("setwin.overflow",  overflow,  1'b0);
    check("setwin.underflow", underflow, 1'b1);
    r_en = 1'b0;
    tick();
    clr_err = 1'b0;
    check("clr2.overflow",  overflow,  1'b0);
    check("clr2.underflow", underflow, 1'b0);

    // 6: async reset mid-stream with count=3
    w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'h61 + 8'(i);
      tick();
    end
    r_en    = 1'b1;
    data_in = 8'h64;
    tick();
    check("mid.count",    count,    4'd3);
    check("mid.data_out", data_out, 8'h61);
    check("mid.rd_valid", rd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("arst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("arst.data_out", data_out, 8'h00);
    check("arst.rd_valid", rd_valid, 1'b0);
    w_en = 1'b0;
    r_en = 1'b0;
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("post.empty", empty, 1'b1);
    w_en    = 1'b1;
    data_in = 8'h71;
    tick();
    w_en = 1'b0;
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    check("post.data_out", data_out, 8'h71);
    check("post.rd_valid", rd_valid, 1'b1);
    check("post.count",    count,    4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
